// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two client ports (data, fetch) and the memory.
interface mem_arbiter_if;
  // data (load/store) port
  logic        d_req;
  logic        d_we;
  logic        d_byte_enable;
  logic        d_byte_select;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  // instruction fetch port
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [15:0] i_rdata;
  // memory side
  logic        mem_en;
  logic        mem_we;
  logic        mem_byte_enable;
  logic        mem_byte_select;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_data_out;
  logic        mem_wait;

  // arbiter view
  modport slave (
    input  d_req, d_we, d_byte_enable, d_byte_select, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    output mem_en, mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata,
    input  mem_data_out, mem_wait
  );

  // requester/memory view
  modport master (
    output d_req, d_we, d_byte_enable, d_byte_select, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    input  mem_en, mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata,
    output mem_data_out, mem_wait
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (data / instruction fetch) single-memory arbiter with burst-limited
// data priority and one-cycle pipelined read return routing.
module mem_arbiter #(
  parameter int unsigned BURST_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic {PRIO_D, PRIO_I} prio_e;

  prio_e      state_q, state_d;
  logic [2:0] burst_cnt_q, burst_cnt_d;
  logic       pend_d_q, pend_d_d;
  logic       pend_i_q, pend_i_d;
  logic       d_gnt, i_gnt;

  // Grant selection: combinational from requests, priority state and mem_wait
  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (!rst && !bus.mem_wait) begin
      if (bus.d_req && bus.i_req) begin
        if (state_q == PRIO_D) d_gnt = 1'b1;
        else                   i_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end else if (bus.i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Memory command mux and read-return routing
  always_comb begin
    bus.d_gnt           = d_gnt;
    bus.i_gnt           = i_gnt;
    bus.mem_en          = d_gnt | i_gnt;
    bus.mem_we          = 1'b0;
    bus.mem_byte_enable = 1'b0;
    bus.mem_byte_select = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_wdata       = '0;
    if (d_gnt) begin
      bus.mem_we          = bus.d_we;
      bus.mem_byte_enable = bus.d_byte_enable;
      bus.mem_byte_select = bus.d_byte_select;
      bus.mem_addr        = bus.d_addr;
      bus.mem_wdata       = bus.d_wdata;
    end else if (i_gnt) begin
      bus.mem_addr        = bus.i_addr;
    end
    // owner flags are masked by rst so a read issued just before reset is dropped
    bus.d_rvalid = pend_d_q & ~rst;
    bus.i_rvalid = pend_i_q & ~rst;
    bus.d_rdata  = bus.d_rvalid ? bus.mem_data_out : '0;
    bus.i_rdata  = bus.i_rvalid ? bus.mem_data_out : '0;
  end

  // Next priority state, burst counter and pending-return owner
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    pend_d_d    = d_gnt & ~bus.d_we;
    pend_i_d    = i_gnt;

    if (i_gnt || !bus.i_req) begin
      burst_cnt_d = '0;
    end else if (d_gnt && burst_cnt_q != 3'h7) begin
      burst_cnt_d = burst_cnt_q + 3'd1;
    end

    case (state_q)
      PRIO_D: begin
        if (d_gnt && bus.i_req && (32'(burst_cnt_q) + 32'd1 == BURST_LIMIT))
          state_d = PRIO_I;
      end
      PRIO_I: begin
        if (i_gnt || !bus.i_req)
          state_d = PRIO_D;
      end
      default: state_d = PRIO_D;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PRIO_D;
      burst_cnt_q <= '0;
      pend_d_q    <= 1'b0;
      pend_i_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      pend_d_q    <= pend_d_d;
      pend_i_q    <= pend_i_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_LIMIT, default 4: maximum consecutive data-port grants while a fetch request is waiting.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 d_req  input  1  data (load/store) port request.
REQ-005 d_we  input  1  data port write enable.
REQ-006 d_byte_enable  input  1  data port byte access.
REQ-007 d_byte_select  input  1  data port byte lane (1 = [15:8]).
REQ-008 d_addr  input  16  data port word address.
REQ-009 d_wdata  input  16  data port write data.
REQ-010 d_gnt  output  1  data request accepted this cycle.
REQ-011 d_rvalid  output  1  data port read data valid.
REQ-012 d_rdata  output  16  data port read data.
REQ-013 i_req  input  1  instruction fetch request (read-only, word access).
REQ-014 i_addr  input  16  fetch word address.
REQ-015 i_gnt  output  1  fetch request accepted this cycle.
REQ-016 i_rvalid  output  1  fetch read data valid.
REQ-017 i_rdata  output  16  fetch read data.
REQ-018 mem_en, mem_we, mem_byte_enable, mem_byte_select  output  1 each  memory command strobes.
REQ-019 mem_addr, mem_wdata  output  16 each  memory address and write data.
REQ-020 mem_data_out  input  16  memory read data, valid one cycle after an accepted read.
REQ-021 mem_wait  input  1  memory busy; no new command is issued while high.

Function
REQ-022 Grant logic is combinational from requests, priority state and mem_wait; at most one of d_gnt/i_gnt is high per cycle.
REQ-023 No grant when mem_wait=1 or rst=1; mem_en equals d_gnt|i_gnt.
REQ-024 On a grant, mem_* outputs carry the granted port's fields; fetch grants drive mem_we=0, mem_byte_enable=0, mem_byte_select=0, mem_wdata=0.
REQ-025 With no grant, mem_we, mem_byte_enable, mem_byte_select, mem_addr and mem_wdata are all 0.
REQ-026 Priority state machine, states PRIO_D (reset state) and PRIO_I: in PRIO_D the data port wins a conflict; in PRIO_I the fetch port wins.
REQ-027 A 3-bit saturating counter burst_cnt increments on each d_gnt while i_req=1, and clears on any i_gnt or when i_req=0.
REQ-028 PRIO_D -> PRIO_I when a d_gnt occurs with i_req=1 and burst_cnt+1 = BURST_LIMIT.
REQ-029 PRIO_I -> PRIO_D on the next i_gnt, or when i_req=0.
REQ-030 A lone requester is granted in either state.
REQ-031 Read return: when a read (d_we=0, or any fetch) is granted in cycle N, the owner port's rvalid is high in cycle N+1 with rdata = mem_data_out; the other port's rvalid stays 0.
REQ-032 Writes produce no rvalid; a write is complete on its grant cycle.
REQ-033 Grants are fully pipelined: a new grant in cycle N+1 is allowed while cycle N's read data returns.
REQ-034 d_rdata and i_rdata are 0 whenever their rvalid is 0.
REQ-035 mem_wait does not delay an already-issued read return.

Reset
REQ-036 While rst=1: d_gnt=i_gnt=mem_en=0, priority state=PRIO_D, burst_cnt=0, and the pending-return owner register is cleared.
REQ-037 A read granted in the cycle before rst is asserted produces no rvalid in the following cycle.
REQ-038 All outputs are 0 in the first cycle after rst deasserts unless a request is present in that cycle.

Verification
REQ-039 Only d_req=1, d_we=0, d_addr=0x0005 -> d_gnt=1, mem_en=1, mem_addr=0x0005; next cycle d_rvalid=1, d_rdata=mem_data_out, i_rvalid=0.
REQ-040 d_req and i_req held high for 12 cycles, BURST_LIMIT=4 -> grant pattern D,D,D,D,I repeating; never 5 consecutive d_gnt.
REQ-041 d_req=1, d_we=1, d_byte_enable=1, d_byte_select=1, d_wdata=0x00AB -> mem_we=1, mem_byte_enable=1, mem_byte_select=1, mem_wdata=0x00AB; no d_rvalid.
REQ-042 Both requests with mem_wait=1 for 3 cycles -> no grant and mem_en=0 during those cycles; first grant goes to the data port in the cycle mem_wait falls.
REQ-043 Fetch read granted at cycle N with rst=1 at cycle N+1 -> i_rvalid=0 at N+1, priority state=PRIO_D, burst_cnt=0.
REQ-044 Alternating grants I,D,I (both reads) -> rvalid is routed to the port granted one cycle earlier on every cycle, with no gaps.
